// File: rtl/core_pkg.sv
// Shared encodings for the MIPS execute stage: ALUop and funct codes, forward
// selects, and the internal ALU control used between decode and the ALU.
package core_pkg;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_SUBU = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [1:0] FWD_BUS   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  typedef enum logic [3:0] {
    AC_ADD, AC_ADDU, AC_SUB, AC_SUBU,
    AC_AND, AC_OR, AC_SLT, AC_SLTU,
    AC_LUI, AC_ZERO
  } alu_ctl_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, zero flag and signed overflow.
// Overflow is only reported for the trapping add/sub operations.
module alu_core
  import core_pkg::*;
#(
  parameter int DW = 32
) (
  input  alu_ctl_e        i_ctl,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  input  logic [15:0]     i_imm16,
  output logic [DW-1:0]   o_result,
  output logic            o_zero,
  output logic            o_ovf
);

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic          w_slt;
  logic          w_sltu;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_slt  = $signed(i_a) < $signed(i_b);
  assign w_sltu = i_a < i_b;

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_ctl)
      AC_ADD: begin
        o_result = w_sum;
        o_ovf    = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
      end
      AC_ADDU: o_result = w_sum;
      AC_SUB: begin
        o_result = w_diff;
        o_ovf    = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
      end
      AC_SUBU: o_result = w_diff;
      AC_AND:  o_result = i_a & i_b;
      AC_OR:   o_result = i_a | i_b;
      AC_SLT:  o_result = {{(DW-1){1'b0}}, w_slt};
      AC_SLTU: o_result = {{(DW-1){1'b0}}, w_sltu};
      AC_LUI:  o_result = {i_imm16, {(DW-16){1'b0}}};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_stage_exmem.sv
// MIPS execute stage: forwarding, immediate extension, ALU, branch target,
// and the EX/MEM pipeline register (captures on the falling clock edge).
module ex_stage_exmem
  import core_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] PC,
  input  logic [RW-1:0] Rt,
  input  logic [RW-1:0] Rd,
  input  logic [15:0]   imm16,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  input  logic          ExtOp,
  input  logic          ALUSrc,
  input  logic          RegDst,
  input  logic          R_type,
  input  logic          MemWr,
  input  logic          Branch,
  input  logic          MemtoReg,
  input  logic          RegWr,
  input  logic [2:0]    ALUop,
  input  logic [1:0]    fwdA,
  input  logic [1:0]    fwdB,
  input  logic [DW-1:0] wb_data,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] store_data,
  output logic [DW-1:0] br_target,
  output logic          br_taken,
  output logic [RW-1:0] wreg,
  output logic          MemWr_out,
  output logic          MemtoReg_out,
  output logic          RegWr_out,
  output logic          ovf,
  output logic          valid
);

  alu_ctl_e      w_ctl;
  logic [DW-1:0] w_opA;
  logic [DW-1:0] w_opB_fwd;
  logic [DW-1:0] w_ext_imm;
  logic [DW-1:0] w_alu_b;
  logic [DW-1:0] w_result;
  logic          w_zero;
  logic          w_ovf;
  logic [DW-1:0] w_br_target;

  logic [DW-1:0] r_alu_out;
  logic [DW-1:0] r_store_data;
  logic [DW-1:0] r_br_target;
  logic          r_br_taken;
  logic [RW-1:0] r_wreg;
  logic          r_memwr;
  logic          r_memtoreg;
  logic          r_regwr;
  logic          r_ovf;
  logic          r_valid;

  always_comb begin
    w_ctl = AC_ZERO;
    if (R_type) begin
      case (imm16[5:0])
        F_ADD:   w_ctl = AC_ADD;
        F_ADDU:  w_ctl = AC_ADDU;
        F_SUB:   w_ctl = AC_SUB;
        F_SUBU:  w_ctl = AC_SUBU;
        F_AND:   w_ctl = AC_AND;
        F_OR:    w_ctl = AC_OR;
        F_SLT:   w_ctl = AC_SLT;
        F_SLTU:  w_ctl = AC_SLTU;
        default: w_ctl = AC_ZERO;
      endcase
    end else begin
      case (ALUop)
        ALU_ADDU: w_ctl = AC_ADDU;
        ALU_SUBU: w_ctl = AC_SUBU;
        ALU_OR:   w_ctl = AC_OR;
        ALU_AND:  w_ctl = AC_AND;
        ALU_SLT:  w_ctl = AC_SLT;
        ALU_SLTU: w_ctl = AC_SLTU;
        ALU_LUI:  w_ctl = AC_LUI;
        default:  w_ctl = AC_ZERO;
      endcase
    end
  end

  // EX/MEM forwarding reads the registered result, so it is stale while stalled.
  always_comb begin
    case (fwdA)
      FWD_EXMEM: w_opA = r_alu_out;
      FWD_WB:    w_opA = wb_data;
      default:   w_opA = busA;
    endcase
    case (fwdB)
      FWD_EXMEM: w_opB_fwd = r_alu_out;
      FWD_WB:    w_opB_fwd = wb_data;
      default:   w_opB_fwd = busB;
    endcase
  end

  assign w_ext_imm   = ExtOp ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
  assign w_alu_b     = ALUSrc ? w_ext_imm : w_opB_fwd;
  assign w_br_target = PC + {{(DW-18){imm16[15]}}, imm16, 2'b00};

  alu_core #(.DW(DW)) u_alu (
    .i_ctl    (w_ctl),
    .i_a      (w_opA),
    .i_b      (w_alu_b),
    .i_imm16  (imm16),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_ovf    (w_ovf)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      r_alu_out    <= '0;
      r_store_data <= '0;
      r_br_target  <= '0;
      r_br_taken   <= 1'b0;
      r_wreg       <= '0;
      r_memwr      <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwr      <= 1'b0;
      r_ovf        <= 1'b0;
      r_valid      <= 1'b0;
    end else if (!stall) begin
      r_alu_out    <= w_result;
      r_store_data <= w_opB_fwd;
      r_br_target  <= w_br_target;
      r_br_taken   <= Branch & w_zero;
      r_wreg       <= RegDst ? Rd : Rt;
      r_memwr      <= MemWr;
      r_memtoreg   <= MemtoReg;
      r_regwr      <= RegWr & ~w_ovf;
      r_ovf        <= w_ovf;
      r_valid      <= 1'b1;
    end
  end

  assign alu_out      = r_alu_out;
  assign store_data   = r_store_data;
  assign br_target    = r_br_target;
  assign br_taken     = r_br_taken;
  assign wreg         = r_wreg;
  assign MemWr_out    = r_memwr;
  assign MemtoReg_out = r_memtoreg;
  assign RegWr_out    = r_regwr;
  assign ovf          = r_ovf;
  assign valid        = r_valid;

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Directed vector bench for ex_stage_exmem: a table of single-instruction
// vectors followed by hand-written stall, flush and reset sequences.
module tb_ex_stage_exmem;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic [4:0]  Rt, Rd;
  logic [15:0] imm16;
  logic [31:0] busA, busB;
  logic        ExtOp, ALUSrc, RegDst, R_type, MemWr, Branch, MemtoReg, RegWr;
  logic [2:0]  ALUop;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] wb_data;
  logic        stall, flush;
  logic [31:0] alu_out, store_data, br_target;
  logic        br_taken;
  logic [4:0]  wreg;
  logic        MemWr_out, MemtoReg_out, RegWr_out, ovf, valid;

  int checks = 0;
  int errors = 0;

  ex_stage_exmem #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .Rt(Rt), .Rd(Rd), .imm16(imm16),
    .busA(busA), .busB(busB), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .R_type(R_type), .MemWr(MemWr), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWr(RegWr), .ALUop(ALUop), .fwdA(fwdA), .fwdB(fwdB), .wb_data(wb_data),
    .stall(stall), .flush(flush), .alu_out(alu_out), .store_data(store_data),
    .br_target(br_target), .br_taken(br_taken), .wreg(wreg),
    .MemWr_out(MemWr_out), .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out),
    .ovf(ovf), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] busa, busb, wb;
    logic        extop, alusrc, regdst, rtype, memwr, branch, memtoreg, regwr;
    logic [2:0]  aluop;
    logic [1:0]  fwda, fwdb;
    logic [31:0] e_alu, e_sd, e_brt;
    logic        e_brtk;
    logic [4:0]  e_wreg;
    logic        e_memwr, e_mtr, e_regwr, e_ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; capture is on the next falling
  // edge and outputs are sampled just after the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    PC = v.pc; imm16 = v.imm; busA = v.busa; busB = v.busb; wb_data = v.wb;
    ExtOp = v.extop; ALUSrc = v.alusrc; RegDst = v.regdst; R_type = v.rtype;
    MemWr = v.memwr; Branch = v.branch; MemtoReg = v.memtoreg; RegWr = v.regwr;
    ALUop = v.aluop; fwdA = v.fwda; fwdB = v.fwdb;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu_out"}, alu_out, 32'h0);
    chk({tag, ".store_data"}, store_data, 32'h0);
    chk({tag, ".br_target"}, br_target, 32'h0);
    chk({tag, ".br_taken"}, br_taken, 1'b0);
    chk({tag, ".wreg"}, wreg, 5'd0);
    chk({tag, ".MemWr_out"}, MemWr_out, 1'b0);
    chk({tag, ".MemtoReg_out"}, MemtoReg_out, 1'b0);
    chk({tag, ".RegWr_out"}, RegWr_out, 1'b0);
    chk({tag, ".ovf"}, ovf, 1'b0);
    chk({tag, ".valid"}, valid, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{imm:16'h0020, busa:32'h7FFFFFFF, busb:32'h1, rtype:1, regdst:1, regwr:1,
                 e_alu:32'h80000000, e_sd:32'h1, e_brt:32'h80, e_wreg:5'd3, e_ovf:1, default:0};
    vecs[1]  = '{imm:16'h0021, busa:32'h7FFFFFFF, busb:32'h1, rtype:1, regdst:1, regwr:1,
                 e_alu:32'h80000000, e_sd:32'h1, e_brt:32'h84, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[2]  = '{imm:16'h0022, busa:32'h80000000, busb:32'h1, rtype:1, regdst:1, regwr:1,
                 e_alu:32'h7FFFFFFF, e_sd:32'h1, e_brt:32'h88, e_wreg:5'd3, e_ovf:1, default:0};
    vecs[3]  = '{imm:16'h0023, busa:32'h3, busb:32'h5, rtype:1, regdst:1, regwr:1,
                 e_alu:32'hFFFFFFFE, e_sd:32'h5, e_brt:32'h8C, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[4]  = '{imm:16'h002A, busa:32'hFFFFFFFF, busb:32'h1, rtype:1, regdst:1, regwr:1,
                 e_alu:32'h1, e_sd:32'h1, e_brt:32'hA8, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[5]  = '{imm:16'h002B, busa:32'hFFFFFFFF, busb:32'h1, rtype:1, regdst:1, regwr:1,
                 e_alu:32'h0, e_sd:32'h1, e_brt:32'hAC, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[6]  = '{imm:16'h0024, busa:32'hF0F0F0F0, busb:32'hFF00FF00, rtype:1, regdst:1, regwr:1,
                 e_alu:32'hF000F000, e_sd:32'hFF00FF00, e_brt:32'h90, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[7]  = '{imm:16'h0025, busa:32'hF0F0F0F0, busb:32'h0F0F0000, rtype:1, regdst:1, regwr:1,
                 e_alu:32'hFFFFF0F0, e_sd:32'h0F0F0000, e_brt:32'h94, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[8]  = '{imm:16'h003F, busa:32'h5, busb:32'h6, rtype:1, regdst:1, regwr:1, branch:1,
                 e_alu:32'h0, e_sd:32'h6, e_brt:32'hFC, e_brtk:1, e_wreg:5'd3, e_regwr:1, default:0};
    vecs[9]  = '{imm:16'hFFFC, busa:32'd16, busb:32'h55, alusrc:1, extop:1, regwr:1, aluop:3'b000,
                 e_alu:32'd12, e_sd:32'h55, e_brt:32'hFFFFFFF0, e_wreg:5'd2, e_regwr:1, default:0};
    vecs[10] = '{imm:16'hFFFC, busa:32'h0, busb:32'h0, alusrc:1, extop:0, regwr:1, aluop:3'b010,
                 e_alu:32'h0000FFFC, e_sd:32'h0, e_brt:32'hFFFFFFF0, e_wreg:5'd2, e_regwr:1, default:0};
    vecs[11] = '{imm:16'h1234, alusrc:1, aluop:3'b110, memwr:1, memtoreg:1,
                 e_alu:32'h12340000, e_brt:32'h48D0, e_wreg:5'd2, e_memwr:1, e_mtr:1, default:0};
    vecs[12] = '{pc:32'h100, imm:16'hFFFF, busa:32'h5, busb:32'h5, branch:1, aluop:3'b001,
                 e_alu:32'h0, e_sd:32'h5, e_brt:32'hFC, e_brtk:1, e_wreg:5'd2, default:0};
    vecs[13] = '{pc:32'h100, imm:16'hFFFF, busa:32'h5, busb:32'h6, branch:1, aluop:3'b001,
                 e_alu:32'hFFFFFFFF, e_sd:32'h6, e_brt:32'hFC, e_wreg:5'd2, default:0};
    vecs[14] = '{busa:32'h4, busb:32'h6, aluop:3'b000, regwr:1,
                 e_alu:32'hA, e_sd:32'h6, e_wreg:5'd2, e_regwr:1, default:0};
    vecs[15] = '{busa:32'h99, busb:32'h77, wb:32'h3, fwda:2'b01, fwdb:2'b10, aluop:3'b001,
                 e_alu:32'h7, e_sd:32'h3, e_wreg:5'd2, default:0};
    vecs[16] = '{busa:32'h99, busb:32'h77, wb:32'h20, fwda:2'b10, fwdb:2'b01, aluop:3'b000,
                 e_alu:32'h27, e_sd:32'h7, e_wreg:5'd2, default:0};
    vecs[17] = '{busa:32'h9, busb:32'h2, wb:32'h55, fwda:2'b11, fwdb:2'b11, aluop:3'b000,
                 e_alu:32'hB, e_sd:32'h2, e_wreg:5'd2, default:0};
    vecs[18] = '{busa:32'h80000000, busb:32'h1, aluop:3'b100,
                 e_alu:32'h1, e_sd:32'h1, e_wreg:5'd2, default:0};
    vecs[19] = '{busa:32'h80000000, busb:32'h1, aluop:3'b101,
                 e_alu:32'h0, e_sd:32'h1, e_wreg:5'd2, default:0};
    vecs[20] = '{busa:32'hFF, busb:32'h0F, aluop:3'b011,
                 e_alu:32'h0F, e_sd:32'h0F, e_wreg:5'd2, default:0};
    vecs[21] = '{busa:32'h5, busb:32'h5, aluop:3'b111, branch:1, regdst:1,
                 e_alu:32'h0, e_sd:32'h5, e_brtk:1, e_wreg:5'd3, default:0};

    Rt = 5'd2; Rd = 5'd3; stall = 1'b0; flush = 1'b0;
    drive('{imm:16'h0021, busa:32'h11, busb:32'h22, regwr:1, memwr:1, default:0});
    rst_n = 1'b0;
    #2;
    chk_zero("reset");
    #5 rst_n = 1'b1;   // t=7, after the first rising edge
    step();
    chk("release.valid", valid, 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d.alu_out", i), alu_out, vecs[i].e_alu);
      chk($sformatf("v%0d.store_data", i), store_data, vecs[i].e_sd);
      chk($sformatf("v%0d.br_target", i), br_target, vecs[i].e_brt);
      chk($sformatf("v%0d.br_taken", i), br_taken, vecs[i].e_brtk);
      chk($sformatf("v%0d.wreg", i), wreg, vecs[i].e_wreg);
      chk($sformatf("v%0d.MemWr_out", i), MemWr_out, vecs[i].e_memwr);
      chk($sformatf("v%0d.MemtoReg_out", i), MemtoReg_out, vecs[i].e_mtr);
      chk($sformatf("v%0d.RegWr_out", i), RegWr_out, vecs[i].e_regwr);
      chk($sformatf("v%0d.ovf", i), ovf, vecs[i].e_ovf);
      chk($sformatf("v%0d.valid", i), valid, 1'b1);
    end

    // Stall for two cycles with changing inputs: everything holds.
    drive('{busa:32'h4, busb:32'h6, aluop:3'b000, regwr:1, memwr:1, default:0});
    step();
    chk("pre_stall.alu_out", alu_out, 32'hA);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive('{busa:32'h100 + k, busb:32'h9, aluop:3'b001, fwda:2'b01, regdst:1, default:0});
      step();
      chk($sformatf("stall%0d.alu_out", k), alu_out, 32'hA);
      chk($sformatf("stall%0d.store_data", k), store_data, 32'h6);
      chk($sformatf("stall%0d.wreg", k), wreg, 5'd2);
      chk($sformatf("stall%0d.RegWr_out", k), RegWr_out, 1'b1);
      chk($sformatf("stall%0d.MemWr_out", k), MemWr_out, 1'b1);
      chk($sformatf("stall%0d.valid", k), valid, 1'b1);
    end

    // Flush wins over stall.
    flush = 1'b1;
    step();
    chk_zero("flush");
    flush = 1'b0;
    stall = 1'b0;
    drive('{busa:32'h3, busb:32'h4, aluop:3'b000, default:0});
    step();
    chk("post_flush.alu_out", alu_out, 32'h7);
    chk("post_flush.valid", valid, 1'b1);

    // Asynchronous reset asserted mid-cycle while stalled clears held state.
    stall = 1'b1;
    drive('{busa:32'h8, busb:32'h8, aluop:3'b000, regwr:1, memwr:1, memtoreg:1, default:0});
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    #3 rst_n = 1'b1;
    step();
    chk("rst_stall.valid", valid, 1'b0);
    chk("rst_stall.alu_out", alu_out, 32'h0);
    stall = 1'b0;
    step();
    chk("rst_resume.valid", valid, 1'b1);
    chk("rst_resume.alu_out", alu_out, 32'h10);
    chk("rst_resume.MemtoReg_out", MemtoReg_out, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_exmem.md
Name: ex_stage_exmem

Overview:
- Consumer side of the ID/EX pipeline register. Takes the decoded operands and controls that ID/EX presents and performs the execute stage.
- Execute stage work: operand forwarding, immediate extension, ALU and branch target. Results are captured into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from hazard control. Flags signed overflow.
- Sits between the ID/EX register and the data-memory stage of the 5-stage MIPS core.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  core clock; EX/MEM captures on the falling edge, like the other pipeline registers
- rst_n  in  1  asynchronous active-low reset
- PC  in  DW  PC+4 of the instruction in EX
- Rt, Rd  in  RW  register indices
- imm16  in  16  immediate; [5:0] is funct when R_type=1
- busA, busB  in  DW  register-file read data
- ExtOp, ALUSrc, RegDst, R_type, MemWr, Branch, MemtoReg, RegWr  in  1 each  decoded controls
- ALUop  in  3  ALU operation for non-R-type instructions
- fwdA, fwdB  in  2  operand source: 00 bus, 01 own EX/MEM alu_out, 10 wb_data, 11 bus
- wb_data  in  DW  write-back stage result
- stall  in  1  hold EX/MEM contents
- flush  in  1  load a bubble
- alu_out  out  DW  registered ALU result
- store_data  out  DW  registered forwarded B operand
- br_target  out  DW  registered PC + (sext(imm16)<<2)
- br_taken  out  1  registered Branch & zero
- wreg  out  RW  registered destination: RegDst ? Rd : Rt
- MemWr_out, MemtoReg_out, RegWr_out  out  1 each  registered controls
- ovf  out  1  registered signed-overflow flag
- valid  out  1  EX/MEM holds a real instruction

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0. Reset has priority over everything; asserting it mid-stall clears the held state.
- Capture happens on negedge clk. Priority is flush > stall > normal load.
- Flush: valid, br_taken, MemWr_out, MemtoReg_out, RegWr_out and ovf go to 0. Data outputs and wreg go to 0.
- Stall (with flush=0): all outputs hold, including the forwarded value seen next cycle.
- Normal load: valid is set to 1. All other outputs load from the combinational EX result of the current inputs. Latency is one clock.
- Operand A comes from the fwdA mux.
- Operand B: opB_fwd comes from the fwdB mux. The ALU B input is ALUSrc ? ext_imm : opB_fwd. store_data = opB_fwd.
- ext_imm is sign-extended when ExtOp=1, else zero-extended.
- R_type=1 decodes funct:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 101010 slt, 101011 sltu
  - any other funct: result 0
- R_type=0 decodes ALUop:
  - 000 addu, 001 subu, 010 or, 011 and, 100 slt, 101 sltu
  - 110 lui: result {imm16, 16'h0}
  - 111: result 0
- Arithmetic: add and sub wrap modulo 2^DW. slt compares signed; sltu compares unsigned.
- zero = (ALU result == 0). It is computed combinationally and used only for br_taken.
- Signed overflow: applies only to funct add or sub. On overflow, ovf=1, RegWr_out is forced to 0, and alu_out still carries the wrapped result.
- br_target wraps modulo 2^DW. br_target is valid regardless of br_taken.
- Forwarding 01 uses the current registered alu_out. This value is stale under stall, which is the intended behaviour.

Decomposition:
- Shared package core_pkg holds:
  - ALUop codes (ALU_ADDU … ALU_LUI)
  - funct constants
  - fwd select codes
  - the internal ALU-control enum
- Natural sub-module: alu_core, combinational. It takes the 4-bit internal ALU control and the operands, and returns result, zero and ovf.
- ex_stage_exmem contains the control decode, the muxes, the extender and the EX/MEM register.

Test Plan:
- Reset: rst_n=0 mid-cycle with nonzero inputs -> all outputs 0 immediately. Release, then one falling edge -> valid=1.
- R-type add overflow: R_type=1, funct 100000, busA=32'h7FFFFFFF, busB=1, RegWr=1 -> alu_out=32'h80000000, ovf=1, RegWr_out=0. Same operands with addu (100001) -> ovf=0, RegWr_out=1.
- Immediate and lui: ALUop=000, ALUSrc=1, ExtOp=1, imm16=16'hFFFC, busA=16 -> alu_out=12. ALUop=110, imm16=16'h1234 -> alu_out=32'h12340000.
- Branch: Branch=1, ALUop=001, busA=busB=5, PC=32'h100, imm16=16'hFFFF -> br_taken=1, br_target=32'hFC. busB=6 -> br_taken=0.
- Forwarding: previous alu_out=32'hA, fwdA=01, fwdB=10, wb_data=3, ALUop=001 -> alu_out=7, store_data=3.
- Stall and flush: stall=1 for 2 cycles with changing inputs -> outputs unchanged. stall=1 and flush=1 together -> valid=0, RegWr_out=0, MemWr_out=0, alu_out=0.
